// File: rtl/seg7_time_display_pkg.sv
// Shared constants for the MM.SS seven-segment display: segment encodings,
// digit-slot indices, the 0..59 clamp limit and small conversion helpers.
package seg7_time_display_pkg;

   localparam int DIG_IDX_W = 2;

   localparam logic [DIG_IDX_W-1:0] DIG_SEC_ONES = 2'd0;
   localparam logic [DIG_IDX_W-1:0] DIG_SEC_TENS = 2'd1;
   localparam logic [DIG_IDX_W-1:0] DIG_MIN_ONES = 2'd2;
   localparam logic [DIG_IDX_W-1:0] DIG_MIN_TENS = 2'd3;

   localparam logic [5:0] CLAMP_MAX = 6'd59;

   // Logical (1 = lit) segment patterns, bit order gfedcba
   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   function automatic logic [5:0] clamp59(input logic [5:0] value);
      if (value > CLAMP_MAX) begin
         clamp59 = CLAMP_MAX;
      end else begin
         clamp59 = value;
      end
   endfunction

   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      case (digit)
         4'd0:    seg_encode = SEG_0;
         4'd1:    seg_encode = SEG_1;
         4'd2:    seg_encode = SEG_2;
         4'd3:    seg_encode = SEG_3;
         4'd4:    seg_encode = SEG_4;
         4'd5:    seg_encode = SEG_5;
         4'd6:    seg_encode = SEG_6;
         4'd7:    seg_encode = SEG_7;
         4'd8:    seg_encode = SEG_8;
         4'd9:    seg_encode = SEG_9;
         default: seg_encode = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/seg7_time_display_if.sv
// Time-in / display-out bundle between the time counter, this display
// driver and the panel. The master side drives the time and adjust controls.
interface seg7_time_display_if;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic       adj;
   logic       sel;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;

   modport master (
      output minutes, seconds, adj, sel,
      input  seg, dp, an
   );

   modport slave (
      input  minutes, seconds, adj, sel,
      output seg, dp, an
   );
endinterface

// File: rtl/seg7_time_display_bin2bcd_59.sv
// Clamps a 6-bit binary value to 0..59 and splits it into BCD tens/ones
// using a compare/subtract ladder instead of a divider.
module bin2bcd_59
   import seg7_time_display_pkg::*;
(
   input  logic [5:0] value_i,
   output logic [3:0] tens_o,
   output logic [3:0] ones_o
);

   logic [5:0] clamped_s;
   logic [5:0] rem_s;

   // Clamp then subtract the largest multiple of ten that fits
   always_comb begin
      clamped_s = clamp59(value_i);
      if (clamped_s >= 6'd50) begin
         tens_o = 4'd5;
         rem_s  = clamped_s - 6'd50;
      end else if (clamped_s >= 6'd40) begin
         tens_o = 4'd4;
         rem_s  = clamped_s - 6'd40;
      end else if (clamped_s >= 6'd30) begin
         tens_o = 4'd3;
         rem_s  = clamped_s - 6'd30;
      end else if (clamped_s >= 6'd20) begin
         tens_o = 4'd2;
         rem_s  = clamped_s - 6'd20;
      end else if (clamped_s >= 6'd10) begin
         tens_o = 4'd1;
         rem_s  = clamped_s - 6'd10;
      end else begin
         tens_o = 4'd0;
         rem_s  = clamped_s;
      end
      ones_o = 4'(rem_s);
   end

endmodule

// File: rtl/seg7_time_display.sv
// Four-digit multiplexed MM.SS driver with frame-coherent snapshot and
// adjust-mode field blinking. Optional macro: LEADING_ZERO_BLANK_EN.
module seg7_time_display
   import seg7_time_display_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 32'd100000,
   parameter int unsigned BLINK_DIV   = 32'd25000000,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   seg7_time_display_if.slave tdisp_io
);

   localparam int RW = (REFRESH_DIV > 32'd1) ? $clog2(REFRESH_DIV) : 32'sd1;
   localparam int BW = (BLINK_DIV > 32'd1) ? $clog2(BLINK_DIV) : 32'sd1;

   localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 32'd1);
   localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 32'd1);

   localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'b1111 : 4'b0000;
   localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
   localparam logic       DP_OFF  = ACTIVE_LOW;

   logic [RW-1:0]        refresh_cnt_q, refresh_cnt_d;
   logic [DIG_IDX_W-1:0] dig_idx_q, dig_idx_d;
   logic [BW-1:0]        blink_cnt_q, blink_cnt_d;
   logic                 blink_phase_q, blink_phase_d;
   logic [5:0]           snap_min_q, snap_min_d;
   logic [5:0]           snap_sec_q, snap_sec_d;
   logic                 load_first_q, load_first_d;
   logic [3:0]           an_q, an_d;
   logic [6:0]           seg_q, seg_d;
   logic                 dp_q, dp_d;

   logic       refresh_wrap_s;
   logic [3:0] min_tens_s, min_ones_s, sec_tens_s, sec_ones_s;
   logic [3:0] digit_val_s;
   logic [3:0] an_onehot_s, an_mask_s, an_act_s;
   logic [6:0] seg_act_s;
   logic       dp_act_s;

   bin2bcd_59 u_bcd_min (
      .value_i (snap_min_q),
      .tens_o  (min_tens_s),
      .ones_o  (min_ones_s)
   );

   bin2bcd_59 u_bcd_sec (
      .value_i (snap_sec_q),
      .tens_o  (sec_tens_s),
      .ones_o  (sec_ones_s)
   );

   // Scan, snapshot and blink timing next-state
   always_comb begin
      refresh_wrap_s = (refresh_cnt_q == REFRESH_LAST);
      if (refresh_wrap_s) begin
         refresh_cnt_d = '0;
         dig_idx_d     = dig_idx_q + 2'd1;
      end else begin
         refresh_cnt_d = refresh_cnt_q + RW'(1'b1);
         dig_idx_d     = dig_idx_q;
      end

      // Sample only at frame boundaries so all four digits agree
      if (load_first_q || (refresh_wrap_s && (dig_idx_q == DIG_MIN_TENS))) begin
         snap_min_d   = tdisp_io.minutes;
         snap_sec_d   = tdisp_io.seconds;
         load_first_d = 1'b0;
      end else begin
         snap_min_d   = snap_min_q;
         snap_sec_d   = snap_sec_q;
         load_first_d = load_first_q;
      end

      if (tdisp_io.adj) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d   = blink_cnt_q + BW'(1'b1);
            blink_phase_d = blink_phase_q;
         end
      end else begin
         blink_cnt_d   = '0;
         blink_phase_d = 1'b0;
      end
   end

   // Digit selection, blanking and polarity for the output register
   always_comb begin
      case (dig_idx_q)
         DIG_SEC_ONES: digit_val_s = sec_ones_s;
         DIG_SEC_TENS: digit_val_s = sec_tens_s;
         DIG_MIN_ONES: digit_val_s = min_ones_s;
         DIG_MIN_TENS: digit_val_s = min_tens_s;
         default:      digit_val_s = 4'd0;
      endcase

      an_onehot_s = 4'b0001 << dig_idx_q;

      if (tdisp_io.adj && blink_phase_q) begin
         if (tdisp_io.sel) begin
            an_mask_s = 4'b0011;
         end else begin
            an_mask_s = 4'b1100;
         end
      end else begin
         an_mask_s = 4'b0000;
      end
`ifdef LEADING_ZERO_BLANK_EN
      if (min_tens_s == 4'd0) begin
         an_mask_s[DIG_MIN_TENS] = 1'b1;
      end else begin
         an_mask_s = an_mask_s;
      end
`endif

      an_act_s = an_onehot_s & ~an_mask_s;
      if (an_act_s != 4'b0000) begin
         seg_act_s = seg_encode(digit_val_s);
      end else begin
         seg_act_s = SEG_BLANK;
      end
      dp_act_s = an_act_s[DIG_MIN_ONES];

      if (ACTIVE_LOW) begin
         an_d  = ~an_act_s;
         seg_d = ~seg_act_s;
         dp_d  = ~dp_act_s;
      end else begin
         an_d  = an_act_s;
         seg_d = seg_act_s;
         dp_d  = dp_act_s;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_cnt_q <= '0;
         dig_idx_q     <= DIG_SEC_ONES;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         snap_min_q    <= 6'd0;
         snap_sec_q    <= 6'd0;
         load_first_q  <= 1'b1;
         an_q          <= AN_OFF;
         seg_q         <= SEG_OFF;
         dp_q          <= DP_OFF;
      end else begin
         refresh_cnt_q <= refresh_cnt_d;
         dig_idx_q     <= dig_idx_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         snap_min_q    <= snap_min_d;
         snap_sec_q    <= snap_sec_d;
         load_first_q  <= load_first_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
      end
   end

   assign tdisp_io.an  = an_q;
   assign tdisp_io.seg = seg_q;
   assign tdisp_io.dp  = dp_q;

endmodule
